// File: rtl/alu_iter.sv
// alu_iter: handshaked execution unit with single-cycle ALU ops, clz/ctz/cpop,
// an iterative shift-add multiplier and an optional iterative restoring divider.
// Build option: define ALU_ITER_DIV_EN to implement divu/remu; otherwise those
// opcodes report illegal and no divider logic is built.
module alu_iter #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [3:0]      alu_control,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] alu_result,
  output logic            zero,
  output logic            illegal
);

  localparam int CNT_W = $clog2(XLEN) + 1;
  localparam int SH_W  = $clog2(XLEN);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_AND  = 4'b0010;
  localparam logic [3:0] OP_OR   = 4'b0011;
  localparam logic [3:0] OP_XOR  = 4'b0100;
  localparam logic [3:0] OP_SLT  = 4'b0101;
  localparam logic [3:0] OP_SLL  = 4'b0110;
  localparam logic [3:0] OP_SRL  = 4'b0111;
  localparam logic [3:0] OP_CLZ  = 4'b1000;
  localparam logic [3:0] OP_CTZ  = 4'b1001;
  localparam logic [3:0] OP_CPOP = 4'b1010;
  localparam logic [3:0] OP_MUL  = 4'b1011;
`ifdef ALU_ITER_DIV_EN
  localparam logic [3:0] OP_DIVU = 4'b1100;
  localparam logic [3:0] OP_REMU = 4'b1101;
`endif

  function automatic logic [CNT_W-1:0] f_clz(input logic [XLEN-1:0] v);
    logic [CNT_W-1:0] n;
    logic             hit;
    n   = '0;
    hit = 1'b0;
    for (int i = XLEN - 1; i >= 0; i--) begin
      if (v[i]) hit = 1'b1;
      else if (!hit) n = n + CNT_W'(1);
    end
    return n;
  endfunction

  function automatic logic [CNT_W-1:0] f_ctz(input logic [XLEN-1:0] v);
    logic [CNT_W-1:0] n;
    logic             hit;
    n   = '0;
    hit = 1'b0;
    for (int i = 0; i < XLEN; i++) begin
      if (v[i]) hit = 1'b1;
      else if (!hit) n = n + CNT_W'(1);
    end
    return n;
  endfunction

  function automatic logic [CNT_W-1:0] f_cpop(input logic [XLEN-1:0] v);
    logic [CNT_W-1:0] n;
    n = '0;
    for (int i = 0; i < XLEN; i++) n = n + CNT_W'(v[i]);
    return n;
  endfunction

  logic [1:0]      state_q, state_d;
  logic [3:0]      op_q, op_d;
  logic [XLEN-1:0] opa_q, opa_d;   // multiplicand / dividend-quotient shifter
  logic [XLEN-1:0] opb_q, opb_d;   // multiplier / divisor
  logic [XLEN-1:0] acc_q, acc_d;   // product accumulator / partial remainder
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [XLEN-1:0] res_q, res_d;
  logic            zero_q, zero_d;
  logic            ill_q, ill_d;

  logic            accept;
  logic            is_iter;
  logic [XLEN-1:0] single_res;
  logic            single_ill;
  logic [XLEN-1:0] iter_res;
`ifdef ALU_ITER_DIV_EN
  logic [XLEN:0]   rem_sh;
  logic [XLEN:0]   diff;
`endif

  assign in_ready   = (state_q == S_IDLE) | ((state_q == S_DONE) & out_ready);
  assign accept     = in_valid & in_ready;
  assign out_valid  = (state_q == S_DONE);
  assign alu_result = res_q;
  assign zero       = zero_q;
  assign illegal    = ill_q;

  // Classify the presented opcode as multi-cycle (goes through BUSY) or not.
  always_comb begin
    is_iter = (alu_control == OP_MUL);
`ifdef ALU_ITER_DIV_EN
    is_iter = is_iter | (alu_control == OP_DIVU) | (alu_control == OP_REMU);
`endif
  end

  // Single-cycle result straight from the presented operands.
  always_comb begin
    // NOTE: every combinational output gets a default first, so no path leaves it unassigned and no latch is inferred.
    single_res = '0;
    single_ill = 1'b0;
    case (alu_control)
      OP_ADD:  single_res = a + b;
      OP_SUB:  single_res = a - b;
      OP_AND:  single_res = a & b;
      OP_OR:   single_res = a | b;
      OP_XOR:  single_res = a ^ b;
      OP_SLT:  single_res = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
      OP_SLL:  single_res = a << b[SH_W-1:0];
      OP_SRL:  single_res = a >> b[SH_W-1:0];
      OP_CLZ:  single_res = XLEN'(f_clz(a));
      OP_CTZ:  single_res = XLEN'(f_ctz(a));
      OP_CPOP: single_res = XLEN'(f_cpop(a));
      default: single_ill = 1'b1;
    endcase
  end

  // Handshake FSM plus one iteration of mul/div per BUSY cycle.
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    opa_d    = opa_q;
    opb_d    = opb_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    res_d    = res_q;
    zero_d   = zero_q;
    ill_d    = ill_q;
    iter_res = '0;
`ifdef ALU_ITER_DIV_EN
    rem_sh   = '0;
    diff     = '0;
`endif
    case (state_q)
      S_BUSY: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (op_q == OP_MUL) begin
          // Shift-add: consume one multiplier bit per cycle, lsb first.
          acc_d    = acc_q + (opb_q[0] ? opa_q : '0);
          opa_d    = opa_q << 1;
          opb_d    = opb_q >> 1;
          iter_res = acc_d;
        end
`ifdef ALU_ITER_DIV_EN
        else begin
          // Restoring divide: bring down the next dividend bit, keep the
          // subtraction only when it does not borrow. A zero divisor never
          // borrows, which yields all-ones quotient and remainder = dividend.
          rem_sh   = {acc_q, opa_q[XLEN-1]};
          diff     = rem_sh - {1'b0, opb_q};
          acc_d    = diff[XLEN] ? rem_sh[XLEN-1:0] : diff[XLEN-1:0];
          opa_d    = {opa_q[XLEN-2:0], ~diff[XLEN]};
          iter_res = (op_q == OP_DIVU) ? opa_d : acc_d;
        end
`endif
        if (cnt_q == CNT_W'(XLEN - 1)) begin
          state_d = S_DONE;
          res_d   = iter_res;
          zero_d  = (iter_res == '0);
          ill_d   = 1'b0;
        end
      end
      S_IDLE, S_DONE: begin
        if (accept) begin
          if (is_iter) begin
            state_d = S_BUSY;
            op_d    = alu_control;
            opa_d   = a;
            opb_d   = b;
            acc_d   = '0;
            cnt_d   = '0;
          end else begin
            state_d = S_DONE;
            res_d   = single_res;
            zero_d  = (single_res == '0);
            ill_d   = single_ill;
          end
        end else if ((state_q == S_DONE) && out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (reset) begin
      state_q <= S_IDLE;
      op_q    <= '0;
      opa_q   <= '0;
      opb_q   <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      res_q   <= '0;
      zero_q  <= 1'b0;
      ill_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
      zero_q  <= zero_d;
      ill_q   <= ill_d;
    end
  end

endmodule

// File: tb/tb_alu_iter.sv
// Self-checking bench for alu_iter: directed vectors with literal expectations,
// plus a scoreboard model that checks every output cycle.
module tb_alu_iter;

  localparam int XLEN = 32;

  logic            clk;
  logic            reset;
  logic            in_valid;
  logic            in_ready;
  logic [3:0]      alu_control;
  logic [XLEN-1:0] a;
  logic [XLEN-1:0] b;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] alu_result;
  logic            zero;
  logic            illegal;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  typedef struct {
    logic [XLEN-1:0] res;
    logic            ill;
    int              lat;
    int              acc_cyc;
  } exp_t;

  exp_t exp_q[$];
  bit   head_seen = 1'b0;

  alu_iter #(.XLEN(XLEN)) dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .alu_control (alu_control),
    .a           (a),
    .b           (b),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .alu_result  (alu_result),
    .zero        (zero),
    .illegal     (illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: bound expired (cycle %0d)", name, cyc);
  endtask

  // Reference behaviour straight from the opcode definitions.
  function automatic exp_t model(input logic [3:0] op, input logic [XLEN-1:0] x, input logic [XLEN-1:0] y);
    exp_t e;
    int   n;
    e.res     = '0;
    e.ill     = 1'b0;
    e.lat     = 1;
    e.acc_cyc = 0;
    n         = 0;
    case (op)
      4'd0:  e.res = x + y;
      4'd1:  e.res = x - y;
      4'd2:  e.res = x & y;
      4'd3:  e.res = x | y;
      4'd4:  e.res = x ^ y;
      4'd5:  e.res = ($signed(x) < $signed(y)) ? XLEN'(1) : XLEN'(0);
      4'd6:  e.res = x << (y % XLEN);
      4'd7:  e.res = x >> (y % XLEN);
      4'd8: begin
        while (n < XLEN && x[XLEN-1-n] == 1'b0) n++;
        e.res = XLEN'(n);
      end
      4'd9: begin
        while (n < XLEN && x[n] == 1'b0) n++;
        e.res = XLEN'(n);
      end
      4'd10: e.res = XLEN'($countones(x));
      4'd11: begin e.res = x * y; e.lat = XLEN + 1; end
`ifdef ALU_ITER_DIV_EN
      4'd12: begin e.res = (y == 0) ? '1 : x / y; e.lat = XLEN + 1; end
      4'd13: begin e.res = (y == 0) ? x : x % y;  e.lat = XLEN + 1; end
`endif
      default: e.ill = 1'b1;
    endcase
    return e;
  endfunction

  // Scoreboard: every cycle, outputs must match the oldest accepted op.
  always @(negedge clk) begin
    exp_t h;
    bit   due;
    if (reset) begin
      exp_q.delete();
      head_seen = 1'b0;
    end else begin
      if (exp_q.size() == 0) begin
        check("idle_out_valid", XLEN'(out_valid), XLEN'(0));
        check("idle_in_ready", XLEN'(in_ready), XLEN'(1));
      end else begin
        h = exp_q[0];
        if (!head_seen) begin
          due = (cyc - h.acc_cyc) >= h.lat;
          check("valid_timing", XLEN'(out_valid), XLEN'(due));
          if (!due) check("busy_in_ready", XLEN'(in_ready), XLEN'(0));
          if (out_valid) head_seen = 1'b1;
        end
        if (out_valid) begin
          check("sb_result", alu_result, h.res);
          check("sb_zero", XLEN'(zero), XLEN'(h.res == '0));
          check("sb_illegal", XLEN'(illegal), XLEN'(h.ill));
          check("sb_in_ready", XLEN'(in_ready), XLEN'(out_ready));
          if (out_ready) begin
            void'(exp_q.pop_front());
            head_seen = 1'b0;
          end
        end
      end
      if (in_valid && in_ready) begin
        h         = model(alu_control, a, b);
        h.acc_cyc = cyc;
        exp_q.push_back(h);
      end
    end
  end

  // Issue one op, scramble inputs after accept, wait for and check its result.
  task automatic do_op(input string name, input logic [3:0] op, input logic [XLEN-1:0] x,
                       input logic [XLEN-1:0] y, input logic [XLEN-1:0] exp_res,
                       input logic exp_ill, input int exp_lat);
    bit got;
    int lat;
    alu_control = op;
    a           = x;
    b           = y;
    in_valid    = 1'b1;
    got         = 1'b0;
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge clk);
      got = in_ready;
      @(posedge clk);
      #2;
    end
    in_valid    = 1'b0;
    a           = $urandom;
    b           = $urandom;
    alu_control = 4'($urandom);
    if (!got) begin
      fail_now({name, "_accept"});
    end else begin
      got = 1'b0;
      lat = 0;
      for (int i = 0; i < 100 && !got; i++) begin
        @(negedge clk);
        if (out_valid) begin
          got = 1'b1;
          lat = i + 1;
        end
      end
      if (!got) begin
        fail_now({name, "_result"});
      end else begin
        check({name, "_result"}, alu_result, exp_res);
        check({name, "_illegal"}, XLEN'(illegal), XLEN'(exp_ill));
        check({name, "_zero"}, XLEN'(zero), XLEN'(exp_res == '0));
        check({name, "_latency"}, XLEN'(lat), XLEN'(exp_lat));
        @(posedge clk);
        #2;
      end
    end
  endtask

  logic [XLEN-1:0] bx [5] = '{32'd10, 32'd100, 32'd7, 32'hFFFF_FFFF, 32'd5};
  logic [XLEN-1:0] by [5] = '{32'd20, 32'd1, 32'd8, 32'd1, 32'd6};
  logic [XLEN-1:0] be [5] = '{32'd30, 32'd101, 32'd15, 32'd0, 32'd11};

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset       = 1'b1;
    in_valid    = 1'b0;
    out_ready   = 1'b1;
    alu_control = '0;
    a           = '0;
    b           = '0;
    repeat (3) @(posedge clk);
    #2 reset = 1'b0;
    @(negedge clk);
    check("rst_out_valid", XLEN'(out_valid), XLEN'(0));
    check("rst_result", alu_result, XLEN'(0));
    check("rst_zero", XLEN'(zero), XLEN'(0));
    check("rst_illegal", XLEN'(illegal), XLEN'(0));
    check("rst_in_ready", XLEN'(in_ready), XLEN'(1));
    @(posedge clk);
    #2;

    do_op("add_ovf",  4'b0000, 32'h7FFF_FFFF, 32'h1,         32'h8000_0000, 1'b0, 1);
    do_op("sub_zero", 4'b0001, 32'd5,         32'd5,         32'h0,         1'b0, 1);
    do_op("and",      4'b0010, 32'hF0F0_FF00, 32'h0FF0_0FF0, 32'h00F0_0F00, 1'b0, 1);
    do_op("or",       4'b0011, 32'h00FF_0000, 32'h0000_FF00, 32'h00FF_FF00, 1'b0, 1);
    do_op("xor",      4'b0100, 32'hAAAA_5555, 32'hFFFF_0000, 32'h5555_5555, 1'b0, 1);
    do_op("slt_neg",  4'b0101, 32'h8000_0000, 32'h1,         32'h1,         1'b0, 1);
    do_op("slt_pos",  4'b0101, 32'h1,         32'h8000_0000, 32'h0,         1'b0, 1);
    do_op("slt_m1",   4'b0101, 32'hFFFF_FFFF, 32'h0,         32'h1,         1'b0, 1);
    do_op("sll_wrap", 4'b0110, 32'h1,         32'd36,        32'h10,        1'b0, 1);
    do_op("srl_31",   4'b0111, 32'h8000_0000, 32'd31,        32'h1,         1'b0, 1);
    do_op("clz_0",    4'b1000, 32'h0,         32'h0,         32'd32,        1'b0, 1);
    do_op("clz_b16",  4'b1000, 32'h0001_0000, 32'h0,         32'd15,        1'b0, 1);
    do_op("ctz_b8",   4'b1001, 32'h0000_0100, 32'h0,         32'd8,         1'b0, 1);
    do_op("ctz_0",    4'b1001, 32'h0,         32'h0,         32'd32,        1'b0, 1);
    do_op("cpop",     4'b1010, 32'hF0F0_F0F0, 32'h0,         32'd16,        1'b0, 1);
    do_op("ill_1111", 4'b1111, 32'h1234_5678, 32'h9,         32'h0,         1'b1, 1);
    do_op("ill_1110", 4'b1110, 32'h1,         32'h1,         32'h0,         1'b1, 1);
    do_op("mul_m1x3", 4'b1011, 32'hFFFF_FFFF, 32'd3,         32'hFFFF_FFFD, 1'b0, XLEN + 1);
    do_op("mul_6x7",  4'b1011, 32'd6,         32'd7,         32'd42,        1'b0, XLEN + 1);
    do_op("mul_wrap", 4'b1011, 32'h0001_0000, 32'h0001_0000, 32'h0,         1'b0, XLEN + 1);
`ifdef ALU_ITER_DIV_EN
    do_op("divu",     4'b1100, 32'd100,       32'd7,         32'd14,        1'b0, XLEN + 1);
    do_op("remu",     4'b1101, 32'd100,       32'd7,         32'd2,         1'b0, XLEN + 1);
    do_op("divu_0",   4'b1100, 32'hDEAD_BEEF, 32'd0,         32'hFFFF_FFFF, 1'b0, XLEN + 1);
    do_op("remu_0",   4'b1101, 32'd9,         32'd0,         32'd9,         1'b0, XLEN + 1);
    do_op("divu_1",   4'b1100, 32'hFFFF_FFFF, 32'd1,         32'hFFFF_FFFF, 1'b0, XLEN + 1);
    do_op("remu_big", 4'b1101, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0, XLEN + 1);
`else
    do_op("divu_ill", 4'b1100, 32'd100,       32'd7,         32'h0,         1'b1, 1);
    do_op("remu_ill", 4'b1101, 32'd100,       32'd7,         32'h0,         1'b1, 1);
`endif

    // Reset in the middle of a multiply: nothing may come out afterwards.
    alu_control = 4'b1011;
    a           = 32'hFFFF_FFFF;
    b           = 32'h7;
    in_valid    = 1'b1;
    @(posedge clk);
    #2 in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #2 reset = 1'b1;
    repeat (2) @(posedge clk);
    #2 reset = 1'b0;
    @(negedge clk);
    check("midrst_out_valid", XLEN'(out_valid), XLEN'(0));
    check("midrst_result", alu_result, XLEN'(0));
    check("midrst_in_ready", XLEN'(in_ready), XLEN'(1));
    repeat (40) @(posedge clk);
    #2;

    // Back-pressure with in_valid held, then back-to-back single-cycle adds.
    out_ready   = 1'b0;
    alu_control = 4'b0000;
    a           = 32'd1;
    b           = 32'd2;
    in_valid    = 1'b1;
    @(posedge clk);
    #2;
    a = bx[0];
    b = by[0];
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("bp_hold_result", alu_result, 32'd3);
      check("bp_hold_ready", XLEN'(in_ready), XLEN'(0));
      @(posedge clk);
      #2;
    end
    out_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      #2;
      if (k < 4) begin
        a = bx[k+1];
        b = by[k+1];
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clk);
      check("b2b_valid", XLEN'(out_valid), XLEN'(1));
      check("b2b_result", alu_result, be[k]);
    end
    repeat (4) @(posedge clk);
    #2;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
